// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I register file: default sizes and the byte-merge
// helpers used by both the register update and the read bypass path.
package rv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // The helpers work on the widest supported word; callers extend and truncate.
  localparam int XLEN_MAX = 64;
  localparam int BE_MAX   = XLEN_MAX / 8;

  function automatic logic [XLEN_MAX-1:0] be_merge(
    input logic [XLEN_MAX-1:0] old_w,
    input logic [XLEN_MAX-1:0] new_w,
    input logic [BE_MAX-1:0]   be
  );
    logic [XLEN_MAX-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_MAX; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  // wr1 is applied first so that any byte wr0 also enables ends up with wr0's data.
  function automatic logic [XLEN_MAX-1:0] wr_merge(
    input logic [XLEN_MAX-1:0] old_w,
    input logic                hit0,
    input logic [XLEN_MAX-1:0] d0,
    input logic [BE_MAX-1:0]   be0,
    input logic                hit1,
    input logic [XLEN_MAX-1:0] d1,
    input logic [BE_MAX-1:0]   be1
  );
    logic [XLEN_MAX-1:0] w1;
    w1 = be_merge(old_w, d1, hit1 ? be1 : '0);
    return be_merge(w1, d0, hit0 ? be0 : '0);
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Load scoreboard: one busy bit per register, set at load issue and cleared by the
// load-return write; produces per-read-port stall flags and busy_any.
module rv_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_en,
  input  logic [AW-1:0]     i_set_addr,
  input  logic              i_clr_en,
  input  logic [AW-1:0]     i_clr_addr,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD-1:0]    o_rd_stall,
  output logic              o_busy_any
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Set is applied after clear: a new load outstanding outranks the returning one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign o_busy_any = |r_busy;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_stall
    logic [AW-1:0] w_addr;
    logic          w_fwd;
    assign w_addr = i_rd_addr[gi*AW +: AW];
    assign w_fwd  = (BYPASS != 0) && i_clr_en && (i_clr_addr == w_addr);
    assign o_rd_stall[gi] = r_busy[w_addr] && (w_addr != '0) && !w_fwd;
  end

endmodule

// File: rtl/rv_regfile_sb.sv
// RV32I integer register file with two byte-strobed write ports (ALU / load return),
// optional write-to-read bypass, load scoreboard and a registered debug read port.
module rv_regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_stall,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic [XLEN/8-1:0]   wr0_be,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic [XLEN/8-1:0]   wr1_be,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  output logic                busy_any,
  output logic                wr_conflict,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  localparam int NBE = XLEN / 8;

  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] r_dbg;
  logic            r_conf;

  function automatic logic [XLEN-1:0] merge_w(
    input logic [XLEN-1:0] old_w,
    input logic            hit0,
    input logic [XLEN-1:0] d0,
    input logic [NBE-1:0]  be0,
    input logic            hit1,
    input logic [XLEN-1:0] d1,
    input logic [NBE-1:0]  be1
  );
    return XLEN'(wr_merge(XLEN_MAX'(old_w), hit0, XLEN_MAX'(d0), BE_MAX'(be0),
                          hit1, XLEN_MAX'(d1), BE_MAX'(be1)));
  endfunction

  // x0 is only ever cleared, so it reads 0 without a dedicated mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        r_regs[r] <= merge_w(r_regs[r],
                             wr0_en && (wr0_addr == AW'(r)), wr0_data, wr0_be,
                             wr1_en && (wr1_addr == AW'(r)), wr1_data, wr1_be);
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit0;
    logic          w_hit1;
    assign w_addr = rd_addr[gi*AW +: AW];
    assign w_hit0 = (BYPASS != 0) && wr0_en && (wr0_addr == w_addr) && (w_addr != '0);
    assign w_hit1 = (BYPASS != 0) && wr1_en && (wr1_addr == w_addr) && (w_addr != '0);
    assign rd_data[gi*XLEN +: XLEN] = merge_w(r_regs[w_addr], w_hit0, wr0_data, wr0_be,
                                              w_hit1, wr1_data, wr1_be);
  end

  // Debug read samples pre-write contents; the conflict flag lags its cause by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg  <= '0;
      r_conf <= 1'b0;
    end else begin
      r_dbg  <= r_regs[dbg_addr];
      r_conf <= wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != '0);
    end
  end

  assign dbg_data    = r_dbg;
  assign wr_conflict = r_conf;

  rv_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (sb_set_en),
    .i_set_addr (sb_set_addr),
    .i_clr_en   (wr1_en),
    .i_clr_addr (wr1_addr),
    .i_rd_addr  (rd_addr),
    .o_rd_stall (rd_stall),
    .o_busy_any (busy_any)
  );

endmodule
